// File: rtl/adder_result_accum_if.sv
// Handshake bundle between the adder, the block accumulator and the next stage:
// the adder result stream in, and the valid/ready block-sum stream out.
interface adder_result_accum_if #(
  parameter int C_W     = 5,
  parameter int BLK_LEN = 4,
  parameter int ACC_W   = C_W + $clog2(BLK_LEN)
);
  logic             in_valid;
  logic [C_W-1:0]   in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  // Driver side: the adder plus the downstream consumer.
  modport master (
    output in_valid,
    output in_c,
    output out_ready,
    input  out_valid,
    input  out_sum
  );

  // Accumulator side.
  modport slave (
    input  in_valid,
    input  in_c,
    input  out_ready,
    output out_valid,
    output out_sum
  );
endinterface

// File: rtl/adder_result_accum.sv
// Sums fixed-length blocks of adder results and offers each block sum on a
// single-entry valid/ready slot; completions that find the slot occupied are dropped.
module adder_result_accum #(
  parameter int C_W     = 5,
  parameter int BLK_LEN = 4,
  parameter int BCNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_result_accum_if.slave   bus,
  input  logic                  clr,
  output logic                  overrun,
  output logic [BCNT_W-1:0]     blk_cnt,
  output logic                  busy
);

  localparam int ACC_W = C_W + $clog2(BLK_LEN);
  localparam int PC_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [PC_W-1:0] LAST = PC_W'(BLK_LEN - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state, state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] blk_sum;
  logic [PC_W-1:0]  part_cnt;
  logic             complete;
  logic             load;
  logic             drop;
  logic [ACC_W-1:0] sum_q;

  // clr takes priority over a coincident valid sample.
  assign complete = bus.in_valid && !clr && (part_cnt == LAST);
  assign blk_sum  = acc + ACC_W'(bus.in_c);

  // NOTE: every register below uses <= so all state updates see pre-edge values;
  // each register gets an explicit reset value so no X ever reaches an output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      part_cnt <= '0;
      busy     <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      part_cnt <= '0;
      busy     <= 1'b0;
    end else if (bus.in_valid) begin
      if (complete) begin
        acc      <= '0;
        part_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        acc      <= blk_sum;
        part_cnt <= part_cnt + PC_W'(1);
        busy     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        if (complete && bus.out_ready) begin
          load = 1'b1;
        end else if (complete) begin
          drop = 1'b1;
        end else if (bus.out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      blk_cnt <= '0;
    end else if (load) begin
      sum_q   <= blk_sum;
      blk_cnt <= blk_cnt + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overrun <= 1'b0;
    else if (clr)  overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  // out_valid comes straight from the state register, never from out_ready.
  assign bus.out_valid = (state == FULL);
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: a queue-based block/slot model checked every cycle,
// plus directed scenarios with literal expectations and a BLK_LEN=1 instance.
module tb_adder_result_accum;
  localparam int C_W     = 5;
  localparam int BLK_LEN = 4;
  localparam int BCNT_W  = 8;

  logic clk = 1'b0;
  logic reset;
  logic clr;
  logic overrun, busy;
  logic [BCNT_W-1:0] blk_cnt;
  logic overrun1, busy1;
  logic [BCNT_W-1:0] blk_cnt1;

  int checks   = 0;
  int failures = 0;

  adder_result_accum_if #(.C_W(C_W), .BLK_LEN(BLK_LEN)) bus ();
  adder_result_accum_if #(.C_W(C_W), .BLK_LEN(1))       bus1 ();

  adder_result_accum #(.C_W(C_W), .BLK_LEN(BLK_LEN), .BCNT_W(BCNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .clr(clr),
    .overrun(overrun), .blk_cnt(blk_cnt), .busy(busy)
  );

  adder_result_accum #(.C_W(C_W), .BLK_LEN(1), .BCNT_W(BCNT_W)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .clr(clr),
    .overrun(overrun1), .blk_cnt(blk_cnt1), .busy(busy1)
  );

  assign bus1.in_valid  = bus.in_valid;
  assign bus1.in_c      = bus.in_c;
  assign bus1.out_ready = 1'b1;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Model: the samples of the current block, and a one-entry output slot.
  int part_q[$];
  bit m_valid;
  int m_sum;
  bit m_over;
  int m_blk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      part_q.delete();
      m_valid = 0;
      m_sum   = 0;
      m_over  = 0;
      m_blk   = 0;
    end else begin
      bit hs, done;
      int s;
      hs   = m_valid && bus.out_ready;
      done = 0;
      s    = 0;
      if (clr) begin
        part_q.delete();
        m_over = 0;
      end else if (bus.in_valid) begin
        part_q.push_back(int'(bus.in_c));
        if (part_q.size() == BLK_LEN) begin
          foreach (part_q[i]) s += part_q[i];
          part_q.delete();
          done = 1;
        end
      end
      if (hs) m_valid = 0;
      if (done) begin
        if (!m_valid) begin
          m_valid = 1;
          m_sum   = s;
          m_blk   = (m_blk + 1) % (1 << BCNT_W);
        end else begin
          m_over = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("cmp_out_valid", int'(bus.out_valid), int'(m_valid));
      if (m_valid) check("cmp_out_sum", int'(bus.out_sum), m_sum);
      check("cmp_overrun", int'(overrun), int'(m_over));
      check("cmp_blk_cnt", int'(blk_cnt), m_blk);
      check("cmp_busy", int'(busy), int'(part_q.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int val);
    bus.in_valid = 1'b1;
    bus.in_c     = C_W'(val);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_c     = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_blk_cnt", int'(blk_cnt), 0);
    reset = 1'b1;
    tick();

    // Basic block; the BLK_LEN=1 instance echoes every sample.
    feed(3);
    check("b1_sum_3", int'(bus1.out_sum), 3);
    check("b1_valid", int'(bus1.out_valid), 1);
    feed(5);
    feed(7);
    check("b1_sum_7", int'(bus1.out_sum), 7);
    feed(9);
    check("t1_out_valid", int'(bus.out_valid), 1);
    check("t1_out_sum", int'(bus.out_sum), 24);
    check("t1_blk_cnt", int'(blk_cnt), 1);
    check("t1_overrun", int'(overrun), 0);
    check("b1_blk_cnt", int'(blk_cnt1), 4);
    tick();
    check("t1_drained", int'(bus.out_valid), 0);

    // Max values with gaps.
    for (int i = 0; i < 4; i++) begin
      feed(31);
      if (i == 0) check("t2_busy_first", int'(busy), 1);
      if (i < 3) repeat (2) tick();
    end
    check("t2_out_sum", int'(bus.out_sum), 124);
    check("t2_busy_done", int'(busy), 0);
    tick();

    // Backpressure and overrun.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(1);
    check("t3_first_sum", int'(bus.out_sum), 4);
    for (int i = 0; i < 4; i++) feed(2);
    check("t3_overrun", int'(overrun), 1);
    check("t3_sum_held", int'(bus.out_sum), 4);
    check("t3_blk_cnt", int'(blk_cnt), 3);
    bus.out_ready = 1'b1;
    tick();
    check("t3_drop_valid", int'(bus.out_valid), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overrun", int'(overrun), 0);

    // Handshake coincident with a completion.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(i);
    check("t4_first_sum", int'(bus.out_sum), 10);
    for (int i = 0; i < 3; i++) feed(5);
    bus.out_ready = 1'b1;
    feed(5);
    check("t4_valid_kept", int'(bus.out_valid), 1);
    check("t4_out_sum", int'(bus.out_sum), 20);
    check("t4_blk_cnt", int'(blk_cnt), 5);
    check("t4_overrun", int'(overrun), 0);
    tick();

    // clr mid-block with a coincident valid.
    feed(6);
    feed(6);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_c     = C_W'(6);
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_busy_cleared", int'(busy), 0);
    check("t5_blk_cnt_kept", int'(blk_cnt), 5);
    for (int i = 0; i < 4; i++) feed(1);
    check("t5_out_sum", int'(bus.out_sum), 4);
    check("t5_blk_cnt", int'(blk_cnt), 6);
    tick();

    // Asynchronous reset between edges.
    feed(2);
    feed(2);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_out_valid", int'(bus.out_valid), 0);
    check("t6_rst_out_sum", int'(bus.out_sum), 0);
    check("t6_rst_blk_cnt", int'(blk_cnt), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_overrun", int'(overrun), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) feed(2);
    check("t6_out_sum", int'(bus.out_sum), 8);
    check("t6_blk_cnt", int'(blk_cnt), 1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_result_accum.md
Name: adder_result_accum

Overview:
- Downstream consumer of the adder stage: samples each adder result `c` qualified by `valid` and sums fixed-length blocks of BLK_LEN results.
- Presents each completed block sum on a valid/ready output port for the next stage, which may apply backpressure.
- The adder has no backpressure, so block completions that find the output slot still occupied are dropped and flagged with a sticky overrun flag.

Parameters:
- C_W, 5, width of the adder result `c` (4-bit operands plus carry).
- BLK_LEN, 4, number of valid results summed per block; legal range 1 to 256.
- ACC_W, C_W+$clog2(BLK_LEN) (7 at defaults), accumulator/output width; derived, must not be overridden.
- BCNT_W, 8, width of the completed-block counter.

Ports:
- clk  input  1  rising-edge clock shared with the adder.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  adder `valid`; in_c is sampled when high.
- in_c  input  C_W  adder result `c`, unsigned.
- clr  input  1  synchronous clear of the partial block and the overrun flag.
- out_valid  output  1  out_sum holds a completed block sum.
- out_ready  input  1  downstream accepts out_sum this cycle.
- out_sum  output  ACC_W  completed block sum, unsigned.
- overrun  output  1  sticky: at least one completed block was dropped.
- blk_cnt  output  BCNT_W  count of blocks accepted into the output slot; wraps at 2^BCNT_W.
- busy  output  1  partial block in progress (part_cnt != 0).

Behaviour:
- Reset (reset=0, asynchronous): acc, part_cnt, out_sum, out_valid, overrun, blk_cnt and busy all go to 0 immediately. Release is synchronous to clk.
- Reset mid-block discards the partial sum and any pending output. The first valid after release starts a new block.
- Accumulate: on each edge with in_valid=1 and clr=0:
  - if part_cnt < BLK_LEN-1: acc <= acc + in_c and part_cnt increments;
  - if part_cnt == BLK_LEN-1, the block completes: sum = acc + in_c, then acc <= 0 and part_cnt <= 0.
- in_valid=0 cycles leave acc and part_cnt unchanged (gaps allowed).
- Width: ACC_W holds BLK_LEN*(2^C_W-1) exactly. No overflow or saturation is possible.
- Output slot FSM:
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on block completion: out_sum <= sum, blk_cnt increments.
  - FULL -> EMPTY on out_valid && out_ready with no completion in the same cycle.
  - FULL -> FULL on a handshake and a completion in the same cycle: the slot reloads with the new sum, out_valid stays 1, blk_cnt increments.
  - FULL with no handshake and a completion: the new sum is dropped, overrun <= 1, out_sum and blk_cnt are unchanged.
- Latency: the edge that samples the final block input makes out_valid=1, so out_sum is visible 1 cycle after the last input.
- out_sum is stable while out_valid=1 and out_ready=0. out_valid does not depend combinationally on out_ready.
- clr=1:
  - acc <= 0, part_cnt <= 0, overrun <= 0.
  - in_valid in the same cycle is ignored (clr wins).
  - The output slot and blk_cnt are unaffected; a handshake in a clr cycle still completes.
- BLK_LEN=1: every valid input completes a block, and out_sum = zero-extended in_c.
- busy is registered and equals (part_cnt != 0).

Test Plan:
1. Basic block (BLK_LEN=4, out_ready=1): in_c 3,5,7,9 on consecutive valid cycles -> out_valid for 1 cycle after the 4th edge, out_sum=24, blk_cnt=1, overrun=0.
2. Max values with gaps: in_c=31 four times, with in_valid low 2 cycles between samples -> out_sum=124, busy high from the 1st sample until completion.
3. Backpressure/overrun: out_ready=0; feed 8 results (1,1,1,1,2,2,2,2) -> out_sum holds 4, overrun=1 after the 8th edge, blk_cnt=1; then out_ready=1 -> out_valid drops next cycle.
4. Simultaneous handshake and completion: slot FULL with 10 and out_ready=1 on the edge the next block (sum 20) completes -> out_valid stays 1, out_sum=20, blk_cnt increments by 1, overrun stays 0.
5. clr mid-block: in_c 6,6 then clr=1 together with in_valid (in_c=6), then 1,1,1,1 -> out_sum=4, overrun cleared, blk_cnt unaffected by clr.
6. Async reset mid-block: reset=0 between clock edges after 2 samples -> all outputs 0 immediately; after release, 2,2,2,2 -> out_sum=8, blk_cnt=1.
